// File: rtl/mem_sweep_pkg.sv
// Shared types and the per-word transform for the sweep engine.
// Modes, FSM states and apply_op live here.
package mem_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_INC  = 2'b10,
    MODE_INV  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_UPDATE
  } state_t;

  localparam int OP_W = 32;

  // Transform one word; w is the live data width, upper bits are masked.
  function automatic logic [OP_W-1:0] apply_op(
    input mode_t           mode,
    input logic [OP_W-1:0] data,
    input logic            saturate,
    input int              w
  );
    logic [OP_W-1:0] mask;
    logic [OP_W-1:0] d;
    logic [OP_W-1:0] r;
    if (w >= OP_W) mask = '1;
    else           mask = (OP_W'(1) << w) - OP_W'(1);
    d = data & mask;
    r = d;
    unique case (mode)
      MODE_PASS: r = d;
      MODE_DEC:  r = (saturate && d == '0) ? d
                   : ((d - OP_W'(1)) & mask);
      MODE_INC:  r = (saturate && d == mask) ? d
                   : ((d + OP_W'(1)) & mask);
      MODE_INV:  r = ~d & mask;
      default:   r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sweep_addr_cntr.sv
// Sweep address counter with clear, increment and last-address flag.
// Wraps from DEPTH-1 to 0 without an extra cycle.
module sweep_addr_cntr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // Address register: clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) addr <= '0;
    else if (inc)   addr <= addr + 1'b1;
  end

  assign last = &addr;

endmodule

// File: rtl/mem_sweep_engine.sv
// Read-modify-write sweep over an internal distributed RAM.
// Each word: FETCH into dout, then UPDATE writes f(dout) back.
module mem_sweep_engine
  import mem_sweep_pkg::*;
#(
  parameter int DATA_W   = 2,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              loop_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic [CNT_W-1:0]  sweep_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t state_q, state_d;
  mode_t  mode_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              cnt_clr, cnt_inc;
  logic              fetch, start_ok;
  logic              done_d, cnt_up;
  logic              ram_we, host_we;
  logic [DATA_W-1:0] wdata;

  sweep_addr_cntr #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .addr (addr),
    .last (last)
  );

  assign wdata = DATA_W'(apply_op(
    mode_q, OP_W'(dout), SATURATE != 0, DATA_W));

  assign host_we  = (state_q == S_IDLE) && wr_en && !rst;
  assign busy     = (state_q != S_IDLE);
  assign addr_out = addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    fetch    = 1'b0;
    start_ok = 1'b0;
    done_d   = 1'b0;
    cnt_up   = 1'b0;
    ram_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        fetch   = 1'b1;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        ram_we  = (mode_q != MODE_PASS);
        cnt_inc = 1'b1;
        state_d = S_FETCH;
        if (last) begin
          cnt_up = 1'b1;
          if (!loop_en) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output, mode and sweep-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      sweep_cnt  <= '0;
      mode_q     <= MODE_PASS;
    end else begin
      dout_valid <= fetch;
      done       <= done_d;
      if (fetch)    dout      <= mem[addr];
      if (start_ok) mode_q    <= mode_t'(mode);
      if (cnt_up)   sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // RAM write port: sweep write-back, else host load while idle.
  always_ff @(posedge clk) begin
    if (ram_we)       mem[addr]    <= wdata;
    else if (host_we) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_mem_sweep_engine.sv
// Bench for mem_sweep_engine: wrap and saturating instances in lockstep
// against a sweep-position model, plus literal checks of known sweeps.
module tb_mem_sweep_engine;

  localparam int DW = 2;
  localparam int AW = 4;
  localparam int CW = 8;
  localparam int D  = 16;
  localparam int M  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, loop_en, wr_en;
  logic [1:0]    mode;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          busy0, done0, val0;
  logic [DW-1:0] dout0;
  logic [AW-1:0] addr0;
  logic [CW-1:0] cnt0;
  logic          busy1, done1, val1;
  logic [DW-1:0] dout1;
  logic [AW-1:0] addr1;
  logic [CW-1:0] cnt1;

  mem_sweep_engine #(
    .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .SATURATE(0)
  ) u0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .loop_en(loop_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy0), .done(done0),
    .dout(dout0), .dout_valid(val0), .addr_out(addr0),
    .sweep_cnt(cnt0)
  );

  mem_sweep_engine #(
    .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .SATURATE(1)
  ) u1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .loop_en(loop_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy1), .done(done1),
    .dout(dout1), .dout_valid(val1), .addr_out(addr1),
    .sweep_cnt(cnt1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // model: sweep position 0..2D-1 (even = fetch, odd = write-back)
  bit busy_m, done_m, valid_m;
  int pos, mode_m, cnt_m, dout0_m, dout1_m;
  int mem0 [D];
  int mem1 [D];

  int vq0[$];
  int vq1[$];
  int s_cyc, fv_cyc, done_cyc;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int f_op(int m, int d, bit sat);
    case (m)
      1:       return sat ? ((d == 0) ? 0 : d - 1) : (d + M - 1) % M;
      2:       return sat ? ((d == M-1) ? d : d + 1) : (d + 1) % M;
      3:       return (M - 1) - d;
      default: return d;
    endcase
  endfunction

  task automatic step();
    int a;
    if (busy_m && (pos % 2) == 1 && mode_m != 0) begin
      a = pos / 2;
      mem0[a] = f_op(mode_m, dout0_m, 1'b0);
      mem1[a] = f_op(mode_m, dout1_m, 1'b1);
    end
    done_m  = 1'b0;
    valid_m = 1'b0;
    if (rst) begin
      busy_m = 1'b0; pos = 0; cnt_m = 0;
      dout0_m = 0; dout1_m = 0;
    end else if (!busy_m) begin
      if (wr_en) begin
        mem0[int'(wr_addr)] = int'(wr_data);
        mem1[int'(wr_addr)] = int'(wr_data);
      end
      if (start) begin
        busy_m = 1'b1; pos = 0; mode_m = int'(mode);
      end
    end else if ((pos % 2) == 0) begin
      dout0_m = mem0[pos/2];
      dout1_m = mem1[pos/2];
      valid_m = 1'b1;
      pos++;
    end else begin
      pos++;
      if (pos == 2*D) begin
        pos = 0;
        cnt_m = (cnt_m + 1) % 256;
        if (!loop_en) begin
          busy_m = 1'b0;
          done_m = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("busy0", busy0, busy_m);
    chk("done0", done0, done_m);
    chk("valid0", val0, valid_m);
    chk("addr0", addr0, pos / 2);
    chk("cnt0", cnt0, cnt_m);
    chk("dout0", dout0, dout0_m);
    chk("busy1", busy1, busy_m);
    chk("done1", done1, done_m);
    chk("valid1", val1, valid_m);
    chk("addr1", addr1, pos / 2);
    chk("cnt1", cnt1, cnt_m);
    chk("dout1", dout1, dout1_m);
    if (val0 === 1'b1) begin
      if (vq0.size() == 0) fv_cyc = cyc;
      vq0.push_back(int'(dout0));
    end
    if (val1 === 1'b1) vq1.push_back(int'(dout1));
    if (done0 === 1'b1) done_cyc = cyc;
  endtask

  task automatic wait_done(string nm);
    int i = 0;
    while (done0 !== 1'b1 && i < 200) begin
      step();
      i++;
    end
    chk(nm, done0, 1);
  endtask

  task automatic sweep(int m);
    vq0.delete();
    vq1.delete();
    mode  = 2'(m);
    start = 1'b1;
    step();
    s_cyc = cyc;
    start = 1'b0;
    wait_done("sweep_done");
  endtask

  task automatic fill(int kind);
    wr_en = 1'b1;
    for (int i = 0; i < D; i++) begin
      wr_addr = AW'(i);
      wr_data = (kind < 0) ? DW'(i % M) : DW'(kind);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int i;
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
    mode = 2'b00; wr_addr = '0; wr_data = '0;
    busy_m = 0; pos = 0; cnt_m = 0; mode_m = 0;
    dout0_m = 0; dout1_m = 0; done_m = 0; valid_m = 0;
    for (int k = 0; k < D; k++) begin
      mem0[k] = 0;
      mem1[k] = 0;
    end

    do_reset();
    chk("rst_busy", busy0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_valid", val0, 0);

    // DEC sweep over i mod 4, latency and wrapped second sweep
    fill(-1);
    sweep(1);
    chk("dec1_len", vq0.size(), D);
    for (int k = 0; k < D && k < vq0.size(); k++)
      chk("dec1_data", vq0[k], k % 4);
    chk("first_valid_lat", fv_cyc - s_cyc, 1);
    chk("done_lat", done_cyc - s_cyc, 2*D);
    sweep(1);
    for (int k = 0; k < D && k < vq0.size(); k++)
      chk("dec2_data", vq0[k], (k + 3) % 4);

    // start/wr_en while busy are ignored
    mode  = 2'b10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) step();
    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 2'd2;
    mode = 2'b00;
    step();
    chk("busy_hold", busy0, 1);
    start = 1'b0; wr_en = 1'b0;
    wait_done("inc_done");
    chk("no_restart_cnt", cnt0, 3);
    sweep(0);
    if (vq0.size() == D) chk("ram5_kept", vq0[5], 0);
    else                 chk("pass_len", vq0.size(), D);

    // same-cycle start and host write
    vq0.delete();
    vq1.delete();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 2'd3;
    mode = 2'b00; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    wait_done("same_cyc_done");
    if (vq0.size() > 0) chk("same_cyc_first", vq0[0], 3);
    else                chk("same_cyc_len", vq0.size(), D);

    // reset in the write-back cycle of addr 7 during INC
    fill(-1);
    mode = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    i = 0;
    while (!(busy_m && pos == 15) && i < 40) begin
      step();
      i++;
    end
    chk("reach_addr7", pos, 15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_dout", dout0, 0);
    chk("mid_rst_cnt", cnt0, 0);
    sweep(0);
    for (int k = 0; k < D && k < vq0.size(); k++)
      chk("mid_rst_data", vq0[k], (k < 8) ? (k + 1) % 4 : k % 4);

    // INV with looping for three sweeps
    do_reset();
    vq0.delete();
    vq1.delete();
    loop_en = 1'b1; mode = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    i = 0;
    while (cnt_m < 2 && i < 100) begin
      step();
      i++;
    end
    loop_en = 1'b0;
    wait_done("loop_done");
    chk("loop_cnt", cnt0, 3);
    chk("loop_len", vq0.size(), 3*D);
    if (vq0.size() == 3*D)
      for (int k = 0; k < D; k++) begin
        chk("inv_s2", vq0[k+D], 3 - vq0[k]);
        chk("inv_s3", vq0[k+2*D], vq0[k]);
      end

    // saturation vs wrap at both ends
    fill(0);
    sweep(1);
    sweep(0);
    for (int k = 0; k < D && k < vq1.size(); k++) begin
      chk("sat_dec", vq1[k], 0);
      chk("wrap_dec", vq0[k], 3);
    end
    fill(3);
    sweep(2);
    sweep(0);
    for (int k = 0; k < D && k < vq1.size(); k++) begin
      chk("sat_inc", vq1[k], 3);
      chk("wrap_inc", vq0[k], 0);
    end

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 7) == 0);
      mode    = 2'($urandom_range(0, 3));
      loop_en = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, D-1));
      wr_data = DW'($urandom_range(0, M-1));
      step();
    end
    rst = 1'b0; start = 1'b0; wr_en = 1'b0; loop_en = 1'b0;
    for (int k = 0; k < 80; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
